// File: rtl/bip_pkg.sv
// Shared definitions for the BIP v2 control unit: opcodes, ALU codes,
// accumulator mux encodings and FSM states.
package bip_pkg;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;
    localparam logic [4:0] OP_AND  = 5'b01000;
    localparam logic [4:0] OP_ANDI = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ORI  = 5'b01011;
    localparam logic [4:0] OP_XOR  = 5'b01100;
    localparam logic [4:0] OP_XORI = 5'b01101;
    localparam logic [4:0] OP_BEQ  = 5'b01110;
    localparam logic [4:0] OP_BNE  = 5'b01111;
    localparam logic [4:0] OP_JMP  = 5'b10000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    localparam logic [1:0] SELA_RAM  = 2'b00;
    localparam logic [1:0] SELA_OPER = 2'b01;
    localparam logic [1:0] SELA_ALU  = 2'b10;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    // Maps an arithmetic/logic opcode (register or immediate form) to its ALU code.
    function automatic logic [2:0] alu_op_of(input logic [4:0] opc);
        logic [2:0] r;
        case (opc)
            OP_SUB, OP_SUBI: r = ALU_SUB;
            OP_AND, OP_ANDI: r = ALU_AND;
            OP_OR,  OP_ORI:  r = ALU_OR;
            OP_XOR, OP_XORI: r = ALU_XOR;
            default:         r = ALU_ADD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder: produces datapath strobes, the illegal flag
// and the branch/halt qualifiers used by the control FSM.
module bip_decoder
    import bip_pkg::*;
#(
    parameter int NB_OPCODE = 5,
    parameter int NB_ALUOP  = 3
) (
    input  logic [NB_OPCODE-1:0] i_opcode,
    input  logic                 i_acc_zero,
    output logic [1:0]           o_sel_a,
    output logic                 o_sel_b,
    output logic                 o_wr_acc,
    output logic [NB_ALUOP-1:0]  o_op,
    output logic                 o_wr_ram,
    output logic                 o_rd_ram,
    output logic                 o_illegal,
    output logic                 o_is_branch,
    output logic                 o_take_branch,
    output logic                 o_is_halt
);

    logic [4:0] w_opc;

    assign w_opc = 5'(i_opcode);

    // Decode the opcode into strobes; anything not listed is flagged illegal.
    always_comb begin
        o_sel_a       = SELA_RAM;
        o_sel_b       = 1'b0;
        o_wr_acc      = 1'b0;
        o_op          = NB_ALUOP'(ALU_ADD);
        o_wr_ram      = 1'b0;
        o_rd_ram      = 1'b0;
        o_illegal     = 1'b0;
        o_is_branch   = 1'b0;
        o_take_branch = 1'b0;
        o_is_halt     = 1'b0;
        case (w_opc)
            OP_HLT: o_is_halt = 1'b1;
            OP_STO: o_wr_ram  = 1'b1;
            OP_LD: begin
                o_sel_a  = SELA_RAM;
                o_wr_acc = 1'b1;
                o_rd_ram = 1'b1;
            end
            OP_LDI: begin
                o_sel_a  = SELA_OPER;
                o_wr_acc = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                o_sel_a  = SELA_ALU;
                o_wr_acc = 1'b1;
                o_rd_ram = 1'b1;
                o_op     = NB_ALUOP'(alu_op_of(w_opc));
            end
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI: begin
                o_sel_a  = SELA_ALU;
                o_sel_b  = 1'b1;
                o_wr_acc = 1'b1;
                o_op     = NB_ALUOP'(alu_op_of(w_opc));
            end
            OP_BEQ: begin
                o_is_branch   = 1'b1;
                o_take_branch = i_acc_zero;
            end
            OP_BNE: begin
                o_is_branch   = 1'b1;
                o_take_branch = ~i_acc_zero;
            end
            OP_JMP: begin
                o_is_branch   = 1'b1;
                o_take_branch = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/bip_control_v2.sv
// BIP v2 control unit: fetch/exec/halt FSM, program counter, instruction
// register and saturating retired-instruction counter.
module bip_control_v2
    import bip_pkg::*;
#(
    parameter int NB_INSTRUC = 16,
    parameter int NB_OPCODE  = 5,
    parameter int NB_OPERAND = 11,
    parameter int NB_ADDR    = 11,
    parameter int NB_ALUOP   = 3,
    parameter int NB_CNT     = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NB_INSTRUC-1:0] i_instr,
    input  logic                  i_instr_valid,
    input  logic                  i_acc_zero,
    output logic [NB_ADDR-1:0]    o_pc,
    output logic                  o_imem_req,
    output logic [NB_OPERAND-1:0] o_operand,
    output logic [1:0]            o_SelA,
    output logic                  o_SelB,
    output logic                  o_WrAcc,
    output logic [NB_ALUOP-1:0]   o_op,
    output logic                  o_WrRam,
    output logic                  o_RdRam,
    output logic                  o_halted,
    output logic                  o_illegal,
    output logic [NB_CNT-1:0]     o_retired
);

    state_t                r_state;
    state_t                w_next_state;
    logic [NB_ADDR-1:0]    r_pc;
    logic [NB_INSTRUC-1:0] r_ir;
    logic [NB_CNT-1:0]     r_retired;

    logic [NB_OPCODE-1:0]  w_opcode;
    logic [NB_ADDR-1:0]    w_target;
    logic                  w_exec;

    logic [1:0]            w_sel_a;
    logic                  w_sel_b;
    logic                  w_wr_acc;
    logic [NB_ALUOP-1:0]   w_op;
    logic                  w_wr_ram;
    logic                  w_rd_ram;
    logic                  w_illegal;
    logic                  w_is_branch;
    logic                  w_take_branch;
    logic                  w_is_halt;

    assign w_opcode = r_ir[NB_INSTRUC-1 -: NB_OPCODE];
    assign w_target = r_ir[NB_ADDR-1:0];
    assign w_exec   = (r_state == ST_EXEC);

    bip_decoder #(
        .NB_OPCODE (NB_OPCODE),
        .NB_ALUOP  (NB_ALUOP)
    ) u_decoder (
        .i_opcode      (w_opcode),
        .i_acc_zero    (i_acc_zero),
        .o_sel_a       (w_sel_a),
        .o_sel_b       (w_sel_b),
        .o_wr_acc      (w_wr_acc),
        .o_op          (w_op),
        .o_wr_ram      (w_wr_ram),
        .o_rd_ram      (w_rd_ram),
        .o_illegal     (w_illegal),
        .o_is_branch   (w_is_branch),
        .o_take_branch (w_take_branch),
        .o_is_halt     (w_is_halt)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_FETCH;
        else       r_state <= w_next_state;
    end

    // Next state: wait for a valid word, execute for one cycle, HALT is absorbing.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH: if (i_instr_valid) w_next_state = ST_EXEC;
            ST_EXEC:  w_next_state = w_is_halt ? ST_HALT : ST_FETCH;
            ST_HALT:  w_next_state = ST_HALT;
            default:  w_next_state = ST_FETCH;
        endcase
    end

    // Capture the fetched word when program memory presents it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                                         r_ir <= '0;
        else if ((r_state == ST_FETCH) && i_instr_valid)   r_ir <= i_instr;
    end

    // Advance PC at the end of EXEC; taken branches load the target, HLT freezes it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= '0;
        end else if (w_exec && !w_is_halt) begin
            if (w_is_branch && w_take_branch) r_pc <= w_target;
            else                              r_pc <= r_pc + NB_ADDR'(1);
        end
    end

    // Count every executed instruction, sticking at all-ones.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                         r_retired <= '0;
        else if (w_exec && (r_retired != '1)) r_retired <= r_retired + NB_CNT'(1);
    end

    // Strobes only leave zero during EXEC; fetch request is held off while in reset.
    always_comb begin
        o_SelA     = SELA_RAM;
        o_SelB     = 1'b0;
        o_WrAcc    = 1'b0;
        o_op       = '0;
        o_WrRam    = 1'b0;
        o_RdRam    = 1'b0;
        o_illegal  = 1'b0;
        o_imem_req = (r_state == ST_FETCH) && !i_rst;
        o_halted   = (r_state == ST_HALT);
        if (w_exec) begin
            o_SelA    = w_sel_a;
            o_SelB    = w_sel_b;
            o_WrAcc   = w_wr_acc;
            o_op      = w_op;
            o_WrRam   = w_wr_ram;
            o_RdRam   = w_rd_ram;
            o_illegal = w_illegal;
        end
    end

    assign o_pc      = r_pc;
    assign o_operand = r_ir[NB_OPERAND-1:0];
    assign o_retired = r_retired;

endmodule
